// File: rtl/ram_queue_if.sv
// Enqueue/dequeue handshake bundle for ram_queue.
// A side transfers on a rising clock edge only when its valid and ready are both high.
// Valid must not wait on ready. Bits are meaningful only while valid is high.
interface ram_queue_if #(
  parameter int WIDTH = 79
);
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits
  );

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits
  );
endinterface

// File: rtl/ram_queue.sv
// Ready/valid FIFO on a DEPTH x WIDTH register array, with wrap at any depth,
// occupancy count, synchronous flush and optional flow-through / pipe modes.
module ram_queue #(
  parameter  int WIDTH = 79,
  parameter  int DEPTH = 5,
  parameter  int FLOW  = 0,
  parameter  int PIPE  = 0,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  ram_queue_if.slave    q,
  output logic [CW-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    enq_ptr;
  logic [PW-1:0]    deq_ptr;
  logic             maybe_full;

  logic ptr_match;
  logic empty;
  logic full;
  logic do_enq;
  logic do_deq;
  logic wr_en;
  logic rd_en;
  logic bypass;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (DEPTH == 1 || p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  always_comb begin
    q.deq_valid = ~empty;
    q.deq_bits  = mem[deq_ptr];
    q.enq_ready = ~full;
    if (FLOW != 0 && empty) begin
      q.deq_valid = q.enq_valid;
      q.deq_bits  = q.enq_bits;
    end
    if (PIPE != 0 && full) begin
      q.enq_ready = q.deq_ready;
    end
  end

  assign do_enq = q.enq_valid & q.enq_ready;
  assign do_deq = q.deq_valid & q.deq_ready;

  // A flow-through transfer into an empty queue never touches storage.
  assign bypass = (FLOW != 0) && empty && q.deq_ready;
  assign wr_en  = do_enq & ~bypass;
  assign rd_en  = do_deq & ~empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else if (flush) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (wr_en) enq_ptr <= next_ptr(enq_ptr);
      if (rd_en) deq_ptr <= next_ptr(deq_ptr);
      if (wr_en != rd_en) maybe_full <= wr_en;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (reset && !flush && wr_en) begin
      mem[enq_ptr] <= q.enq_bits;
    end
  end

  always_comb begin
    logic [CW:0] diff;
    diff = '0;
    if (ptr_match) begin
      diff = maybe_full ? (CW+1)'(DEPTH) : '0;
    end else if (enq_ptr > deq_ptr) begin
      diff = (CW+1)'(enq_ptr) - (CW+1)'(deq_ptr);
    end else begin
      diff = (CW+1)'(DEPTH) + (CW+1)'(enq_ptr) - (CW+1)'(deq_ptr);
    end
    count = diff[CW-1:0];
  end

  a_enq_ptr_range: assert property (@(posedge clock) disable iff (!reset)
    32'(enq_ptr) < DEPTH);
  a_deq_ptr_range: assert property (@(posedge clock) disable iff (!reset)
    32'(deq_ptr) < DEPTH);
  a_count_range: assert property (@(posedge clock) disable iff (!reset)
    32'(count) <= DEPTH);

endmodule

// File: tb/tb_ram_queue.sv
// Random and directed stimulus for three ram_queue variants (plain, FLOW, PIPE)
// checked against a queue-based model of FIFO behaviour.
module tb_ram_queue;
  localparam int W     = 79;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NI    = 3;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          enq_valid;
  logic [W-1:0]  enq_bits;
  logic          deq_ready;

  logic          er  [NI];
  logic          dv  [NI];
  logic [W-1:0]  db  [NI];
  logic [CW-1:0] cnt [NI];

  int passed;
  int total;

  logic [W-1:0] exp_q [NI][$];

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  ram_queue_if #(.WIDTH(W)) qi [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign qi[g].enq_valid = enq_valid;
    assign qi[g].enq_bits  = enq_bits;
    assign qi[g].deq_ready = deq_ready;
    assign er[g]           = qi[g].enq_ready;
    assign dv[g]           = qi[g].deq_valid;
    assign db[g]           = qi[g].deq_bits;

    ram_queue #(
      .WIDTH(W),
      .DEPTH(DEPTH),
      .FLOW ((g == 1) ? 1 : 0),
      .PIPE ((g == 2) ? 1 : 0)
    ) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .q     (qi[g]),
      .count (cnt[g])
    );
  end

  function automatic logic [W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  function automatic void chk(input string nm, input int i,
                              input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, i, act, exp, $time);
  endfunction

  // scoreboard monitor: model is an ordered list of stored entries per variant
  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      int   n;
      logic flow_m;
      logic pipe_m;
      logic edv;
      logic eer;
      if (!reset) exp_q[i].delete();
      n      = exp_q[i].size();
      flow_m = (i == 1);
      pipe_m = (i == 2);
      edv    = (n > 0) || (flow_m && enq_valid);
      eer    = (n < DEPTH) || (pipe_m && deq_ready);
      chk("count", i, W'(cnt[i]), W'(n));
      chk("enq_ready", i, W'(er[i]), W'(eer));
      chk("deq_valid", i, W'(dv[i]), W'(edv));
      if (edv) chk("deq_bits", i, db[i], (n > 0) ? exp_q[i][0] : enq_bits);
      if (reset) begin
        if (flush) begin
          exp_q[i].delete();
        end else if (!(flow_m && n == 0 && enq_valid && deq_ready)) begin
          if (n > 0 && deq_ready) void'(exp_q[i].pop_front());
          if (enq_valid && eer) exp_q[i].push_back(enq_bits);
        end
      end
    end
  end

  // driver
  task automatic cyc(input logic ev, input logic [W-1:0] b,
                     input logic dr, input logic fl);
    enq_valid = ev;
    enq_bits  = b;
    deq_ready = dr;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_bits  = '0;
    deq_ready = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // fill to full, then a rejected sixth enqueue
    for (int k = 1; k <= 5; k++) cyc(1'b1, W'(k), 1'b0, 1'b0);
    cyc(1'b1, W'('h66), 1'b0, 1'b0);

    // drain with wrap and interleaved enqueues
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int k = 6; k <= 8; k++) cyc(1'b1, W'(k), 1'b1, 1'b0);
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b0);

    // steady simultaneous enq/deq at count 3
    repeat (3) cyc(1'b1, rnd(), 1'b0, 1'b0);
    repeat (10) cyc(1'b1, rnd(), 1'b1, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

    // enqueue into empty with consumer ready
    cyc(1'b1, W'('h7FFF), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // full queue: swap with deq_ready, then blocked without it
    repeat (6) cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b1, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

    // flush at count 4 with a concurrent enqueue
    repeat (4) cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // asynchronous reset between edges at count 2
    repeat (2) cyc(1'b1, rnd(), 1'b0, 1'b0);
    enq_valid = 1'b0;
    #2 reset  = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    // random traffic, producer-heavy then consumer-heavy
    for (int k = 0; k < 400; k++) begin
      logic dr;
      dr = (k < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      cyc(1'($urandom_range(0, 1)), rnd(), dr, 1'($urandom_range(0, 39) == 0));
    end
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
